uart_alici_gelismis: RTL

//  Parametrised UART receiver. Runtime baud divisor, 5-9 data bits, optional parity, 1/2 stop bits.
//  3-sample majority voting; glitch rejection; parity/framing/break/overrun flags.

---
 rtl/uart_alici_gelismis_pkg.sv | 27 ++
 rtl/uart_alici_fifo.sv | 60 ++++++
 rtl/uart_alici_gelismis.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_alici_gelismis_pkg.sv
// uart_alici_gelismis_pkg
//   Shared definitions for the UART receiver: FSM state encoding, parity mode
//   codes, the default (fastest) divisor and the 3-sample majority helper.
package uart_alici_gelismis_pkg;

  typedef enum logic [2:0] {
    ALICI_BOSTA,
    ALICI_BASLA,
    ALICI_VERI,
    ALICI_ESLIK,
    ALICI_DUR1,
    ALICI_DUR2,
    ALICI_BEKLE
  } alici_durum_t;

  // eslik_mod codes; 2'b00 and 2'b11 both mean "no parity bit"
  localparam logic [1:0] ESLIK_CIFT = 2'b01;
  localparam logic [1:0] ESLIK_TEK  = 2'b10;

  // Divisor value that yields one oversample tick per clock
  localparam int FAST_UART_BOLEN = 0;

  function automatic logic cogunluk(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_alici_fifo.sv
// uart_alici_fifo
//   Synchronous FIFO holding received words with their error flags.
//   Only instantiated when UART_ALICI_FIFO_EN is defined.
// Ports
//   clk_g, rst_g : clock, asynchronous active-high reset
//   push, din    : write request / data (ignored when full and not popping)
//   pop          : read request (ignored when empty)
//   dout         : head entry
//   full, empty  : occupancy status
module uart_alici_fifo #(
  parameter int W        = 11,
  parameter int DERINLIK = 4
) (
  input  logic         clk_g,
  input  logic         rst_g,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DERINLIK);

  logic [W-1:0]  mem [DERINLIK];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   sayac;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (sayac == '0);
  assign full    = (sayac == (AW+1)'(DERINLIK));
  assign pop_ok  = pop & ~empty;
  // a simultaneous pop frees the slot the push needs
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      sayac  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   sayac <= sayac + 1'b1;
        2'b01:   sayac <= sayac - 1'b1;
        default: sayac <= sayac;
      endcase
    end
  end

  always_ff @(posedge clk_g) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_alici_gelismis.sv
// uart_alici_gelismis
//   UART receiver: 2-FF RX synchroniser, runtime baud divisor, ORNEK-times
//   oversampling with 3-sample majority, 5..9 data bits, optional parity,
//   1 or 2 stop bits, parity/framing/break/overrun reporting and a
//   valid/ready output handshake.
//   Build option: define UART_ALICI_FIFO_EN to replace the single holding
//   register with a FIFO_DERINLIK-entry FIFO (uart_alici_fifo).
// Ports
//   clk_g, rst_g   : clock, asynchronous active-high reset
//   RX             : serial line (idle high, asynchronous)
//   bolen          : tick divisor, baud = f_clk/((bolen+1)*ORNEK)
//   eslik_mod      : 01 even, 10 odd, 00/11 no parity
//   dur_iki        : 1 = two stop bits
//   al_veri        : received word, LSB first on the line
//   al_gecerli     : word and flags valid, held until al_hazir
//   al_hazir       : consumer ready
//   eslik_hata, cerceve_hata, kesme : flags of the presented word
//   tasma          : one-cycle pulse when a completed frame is dropped
module uart_alici_gelismis
  import uart_alici_gelismis_pkg::*;
#(
  parameter int VERI_BIT      = 8,
  parameter int ORNEK         = 16,
  parameter int BOLEN_W       = 16,
  parameter int FIFO_DERINLIK = 4
) (
  input  logic                clk_g,
  input  logic                rst_g,
  input  logic                RX,
  input  logic [BOLEN_W-1:0]  bolen,
  input  logic [1:0]          eslik_mod,
  input  logic                dur_iki,
  output logic [VERI_BIT-1:0] al_veri,
  output logic                al_gecerli,
  input  logic                al_hazir,
  output logic                eslik_hata,
  output logic                cerceve_hata,
  output logic                kesme,
  output logic                tasma
);
  localparam int SW = $clog2(ORNEK);
  localparam int KW = VERI_BIT + 3;
  localparam logic [SW-1:0] ORNEK_A   = SW'(ORNEK / 2 - 1);
  localparam logic [SW-1:0] ORNEK_B   = SW'(ORNEK / 2);
  localparam logic [SW-1:0] ORNEK_C   = SW'(ORNEK / 2 + 1);
  localparam logic [SW-1:0] ORNEK_SON = SW'(ORNEK - 1);

  if (VERI_BIT < 5 || VERI_BIT > 9 || ORNEK < 8 || (ORNEK % 2) != 0 ||
      FIFO_DERINLIK < 2 || (FIFO_DERINLIK & (FIFO_DERINLIK - 1)) != 0) begin : g_param_hata
    $error("uart_alici_gelismis: unsupported parameter combination");
  end

  alici_durum_t         durum, durum_n;
  logic                 rx_s1, rx_s2, rx_sync;
  logic [BOLEN_W-1:0]   tick_say, bolen_l;
  logic [SW-1:0]        ornek_say;
  logic [2:0]           orn;
  logic [VERI_BIT-1:0]  veri_kay;
  logic [3:0]           bit_say;
  logic [1:0]           eslik_l;
  logic                 dur_iki_l, eslik_bit, cerceve_acc;
  logic                 tick, karar_an, orta_son, bit_deger, dur_deger;
  logic                 baslat, veri_kaydir, eslik_al, dur_al, tamamla;
  logic                 eslik_kul, beklenen_eslik, cerceve_n, eslik_hata_n, kesme_n;
  logic                 yaz;
  logic [KW-1:0]        yaz_kayit, bas;
  logic                 gecerli, dolu, pop, yukle;

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
    end
  end
  assign rx_sync = rx_s2;

  assign tick      = (durum != ALICI_BOSTA) && (tick_say == bolen_l);
  assign karar_an  = tick && (ornek_say == ORNEK_SON);
  assign orta_son  = tick && (ornek_say == ORNEK_C);
  assign bit_deger = cogunluk(orn[0], orn[1], orn[2]);
  // the last stop bit is decided on its third sample, before it is registered
  assign dur_deger = cogunluk(orn[0], orn[1], rx_sync);

  assign eslik_kul      = (eslik_l == ESLIK_CIFT) || (eslik_l == ESLIK_TEK);
  assign beklenen_eslik = (eslik_l == ESLIK_CIFT) ? ^veri_kay : ~^veri_kay;
  assign cerceve_n      = cerceve_acc | ~dur_deger;
  assign eslik_hata_n   = eslik_kul & (eslik_bit != beklenen_eslik);
  assign kesme_n        = (veri_kay == '0) & ~(eslik_kul & eslik_bit) & cerceve_n;

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) durum <= ALICI_BOSTA;
    else       durum <= durum_n;
  end

  always_comb begin
    durum_n     = durum;
    baslat      = 1'b0;
    veri_kaydir = 1'b0;
    eslik_al    = 1'b0;
    dur_al      = 1'b0;
    tamamla     = 1'b0;
    case (durum)
      ALICI_BOSTA: if (!rx_sync) begin
        durum_n = ALICI_BASLA;
        baslat  = 1'b1;
      end
      ALICI_BASLA: if (karar_an) durum_n = bit_deger ? ALICI_BOSTA : ALICI_VERI;
      ALICI_VERI: if (karar_an) begin
        veri_kaydir = 1'b1;
        if (bit_say == 4'(VERI_BIT - 1)) durum_n = eslik_kul ? ALICI_ESLIK : ALICI_DUR1;
      end
      ALICI_ESLIK: if (karar_an) begin
        eslik_al = 1'b1;
        durum_n  = ALICI_DUR1;
      end
      ALICI_DUR1: begin
        if (dur_iki_l) begin
          if (karar_an) begin
            dur_al  = 1'b1;
            durum_n = ALICI_DUR2;
          end
        end else if (orta_son) begin
          tamamla = 1'b1;
          durum_n = (kesme_n || !rx_sync) ? ALICI_BEKLE : ALICI_BOSTA;
        end
      end
      ALICI_DUR2: if (orta_son) begin
        tamamla = 1'b1;
        durum_n = (kesme_n || !rx_sync) ? ALICI_BEKLE : ALICI_BOSTA;
      end
      ALICI_BEKLE: if (rx_sync) durum_n = ALICI_BOSTA;
      default: durum_n = ALICI_BOSTA;
    endcase
  end

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      tick_say    <= '0;
      ornek_say   <= '0;
      orn         <= 3'b111;
      veri_kay    <= '0;
      bit_say     <= '0;
      eslik_bit   <= 1'b0;
      cerceve_acc <= 1'b0;
      bolen_l     <= BOLEN_W'(FAST_UART_BOLEN);
      eslik_l     <= '0;
      dur_iki_l   <= 1'b0;
    end else begin
      if (durum == ALICI_BOSTA) begin
        tick_say  <= '0;
        ornek_say <= '0;
      end else if (tick) begin
        tick_say  <= '0;
        ornek_say <= (ornek_say == ORNEK_SON) ? '0 : ornek_say + 1'b1;
      end else begin
        tick_say  <= tick_say + 1'b1;
      end
      if (tick && ornek_say == ORNEK_A) orn[0] <= rx_sync;
      if (tick && ornek_say == ORNEK_B) orn[1] <= rx_sync;
      if (tick && ornek_say == ORNEK_C) orn[2] <= rx_sync;
      if (baslat) begin
        bolen_l     <= bolen;
        eslik_l     <= eslik_mod;
        dur_iki_l   <= dur_iki;
        bit_say     <= '0;
        eslik_bit   <= 1'b0;
        cerceve_acc <= 1'b0;
      end
      if (veri_kaydir) begin
        veri_kay <= {bit_deger, veri_kay[VERI_BIT-1:1]};
        bit_say  <= bit_say + 1'b1;
      end
      if (eslik_al) eslik_bit <= bit_deger;
      if (dur_al && !bit_deger) cerceve_acc <= 1'b1;
    end
  end

  // completed frame is staged one cycle before it reaches storage
  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      yaz       <= 1'b0;
      yaz_kayit <= '0;
    end else begin
      yaz <= tamamla;
      if (tamamla) yaz_kayit <= {kesme_n, cerceve_n, eslik_hata_n, veri_kay};
    end
  end

  assign pop   = gecerli & al_hazir;
  assign yukle = yaz & (~dolu | pop);

`ifdef UART_ALICI_FIFO_EN
  logic bos;
  uart_alici_fifo #(.W(KW), .DERINLIK(FIFO_DERINLIK)) u_fifo (
    .clk_g (clk_g),
    .rst_g (rst_g),
    .push  (yukle),
    .pop   (pop),
    .din   (yaz_kayit),
    .dout  (bas),
    .full  (dolu),
    .empty (bos)
  );
  assign gecerli = ~bos;
`else
  logic [KW-1:0] tut;
  logic          tut_dolu;
  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      tut      <= '0;
      tut_dolu <= 1'b0;
    end else if (yukle) begin
      tut      <= yaz_kayit;
      tut_dolu <= 1'b1;
    end else if (pop) begin
      tut_dolu <= 1'b0;
    end
  end
  assign bas     = tut;
  assign dolu    = tut_dolu;
  assign gecerli = tut_dolu;
`endif

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) tasma <= 1'b0;
    else       tasma <= yaz & dolu & ~pop;
  end

  assign al_gecerli = gecerli;
  assign {kesme, cerceve_hata, eslik_hata, al_veri} = gecerli ? bas : '0;

endmodule
